// File: rtl/l2_request_arbiter.sv
// Shares the single L2 port between the L1 I-cache and the L1 D-cache.
// One grant at a time, held until L2 responds, then a one-cycle release gap.
module l2_request_arbiter #(
  parameter int MEM_PRIORITY = 0,
  parameter int TIMEOUT      = 255
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [15:0]  IF_address,
  input  logic         IF_read,
  input  logic         IF_write,
  input  logic [127:0] IF_wdata,
  input  logic [15:0]  MEM_address,
  input  logic         MEM_read,
  input  logic         MEM_write,
  input  logic [127:0] MEM_wdata,
  output logic         l2i_resp,
  output logic [127:0] l2i_rdata,
  output logic         l2d_resp,
  output logic [127:0] l2d_rdata,
  output logic [15:0]  l2_address,
  output logic         l2_read,
  output logic         l2_write,
  output logic [127:0] l2_wdata,
  input  logic         l2_resp,
  input  logic [127:0] l2_rdata,
  output logic         l2_timeout
);

  typedef enum logic [1:0] {IDLE, SERVE_IF, SERVE_MEM, RELEASE} state_t;

  localparam logic [7:0] TO_LIMIT = (TIMEOUT > 255) ? 8'd255 : 8'(TIMEOUT);
  localparam bit         TO_EN    = (TIMEOUT != 0);

  state_t       state_q, state_d;
  logic         last_mem_q, last_mem_d;
  logic [7:0]   wait_cnt_q, wait_cnt_d;
  logic         timeout_q, timeout_d;
  logic [127:0] irdata_q, irdata_d;
  logic [127:0] drdata_q, drdata_d;

  logic req_if, req_mem, grant_mem;

  assign req_if  = IF_read | IF_write;
  assign req_mem = MEM_read | MEM_write;
  // On a tie MEM wins under fixed priority, otherwise the side that was not served last.
  assign grant_mem = req_mem & (~req_if | (MEM_PRIORITY != 0) | ~last_mem_q);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      last_mem_q <= 1'b1;
      wait_cnt_q <= 8'd0;
      timeout_q  <= 1'b0;
      irdata_q   <= '0;
      drdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      last_mem_q <= last_mem_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
      irdata_q   <= irdata_d;
      drdata_q   <= drdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_mem_d = last_mem_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    unique case (state_q)
      IDLE: begin
        if (req_if || req_mem) begin
          state_d    = grant_mem ? SERVE_MEM : SERVE_IF;
          last_mem_d = grant_mem;
          wait_cnt_d = 8'd0;
        end
      end
      SERVE_IF, SERVE_MEM: begin
        if (l2_resp) begin
          state_d = RELEASE;
        end else if (wait_cnt_q != 8'hFF) begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
        if (TO_EN && (wait_cnt_d == TO_LIMIT)) begin
          timeout_d = 1'b1;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath to L2 and back to the granted requester; a write on the same cycle masks the read.
  always_comb begin
    l2_address = 16'd0;
    l2_wdata   = '0;
    l2_read    = 1'b0;
    l2_write   = 1'b0;
    l2i_resp   = 1'b0;
    l2d_resp   = 1'b0;
    irdata_d   = irdata_q;
    drdata_d   = drdata_q;
    unique case (state_q)
      SERVE_IF: begin
        l2_address = IF_address;
        l2_wdata   = IF_wdata;
        l2_write   = IF_write;
        l2_read    = IF_read & ~IF_write;
        if (l2_resp) begin
          l2i_resp = 1'b1;
          irdata_d = l2_rdata;
        end
      end
      SERVE_MEM: begin
        l2_address = MEM_address;
        l2_wdata   = MEM_wdata;
        l2_write   = MEM_write;
        l2_read    = MEM_read & ~MEM_write;
        if (l2_resp) begin
          l2d_resp = 1'b1;
          drdata_d = l2_rdata;
        end
      end
      default: ;
    endcase
  end

  assign l2i_rdata  = l2i_resp ? l2_rdata : irdata_q;
  assign l2d_rdata  = l2d_resp ? l2_rdata : drdata_q;
  assign l2_timeout = timeout_q;

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Directed bench for l2_request_arbiter: round-robin/timeout instance and fixed-MEM-priority instance.
module tb_l2_request_arbiter;

  localparam logic [127:0] RD_A5 = {16{8'hA5}};
  localparam logic [127:0] WD_IF = {16{8'h11}};
  localparam logic [127:0] WD_M3 = {16{8'h3C}};
  localparam logic [127:0] WD_M4 = {16{8'h44}};
  localparam logic [127:0] WD_M5 = {16{8'h5A}};
  localparam logic [127:0] RD_5  = {16{8'hC5}};
  localparam logic [127:0] RD_6  = {16{8'hE6}};

  logic         clk = 1'b0;
  logic         reset_n;
  logic [15:0]  IF_address, MEM_address;
  logic         IF_read, IF_write, MEM_read, MEM_write;
  logic [127:0] IF_wdata, MEM_wdata;
  logic         l2_resp;
  logic [127:0] l2_rdata;

  logic         iresp_a, dresp_a, rd_a, wr_a, to_a;
  logic [127:0] irdata_a, drdata_a, wdata_a;
  logic [15:0]  addr_a;
  logic         iresp_b, dresp_b, rd_b, wr_b, to_b;
  logic [127:0] irdata_b, drdata_b, wdata_b;
  logic [15:0]  addr_b;

  logic         sel;
  logic         m_iresp, m_dresp, m_rd, m_wr, m_to;
  logic [127:0] m_irdata, m_drdata, m_wdata;
  logic [15:0]  m_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  l2_request_arbiter #(.MEM_PRIORITY(0), .TIMEOUT(4)) u_rr (
    .clk(clk), .reset_n(reset_n),
    .IF_address(IF_address), .IF_read(IF_read), .IF_write(IF_write), .IF_wdata(IF_wdata),
    .MEM_address(MEM_address), .MEM_read(MEM_read), .MEM_write(MEM_write), .MEM_wdata(MEM_wdata),
    .l2i_resp(iresp_a), .l2i_rdata(irdata_a), .l2d_resp(dresp_a), .l2d_rdata(drdata_a),
    .l2_address(addr_a), .l2_read(rd_a), .l2_write(wr_a), .l2_wdata(wdata_a),
    .l2_resp(l2_resp), .l2_rdata(l2_rdata), .l2_timeout(to_a)
  );

  l2_request_arbiter #(.MEM_PRIORITY(1), .TIMEOUT(255)) u_mp (
    .clk(clk), .reset_n(reset_n),
    .IF_address(IF_address), .IF_read(IF_read), .IF_write(IF_write), .IF_wdata(IF_wdata),
    .MEM_address(MEM_address), .MEM_read(MEM_read), .MEM_write(MEM_write), .MEM_wdata(MEM_wdata),
    .l2i_resp(iresp_b), .l2i_rdata(irdata_b), .l2d_resp(dresp_b), .l2d_rdata(drdata_b),
    .l2_address(addr_b), .l2_read(rd_b), .l2_write(wr_b), .l2_wdata(wdata_b),
    .l2_resp(l2_resp), .l2_rdata(l2_rdata), .l2_timeout(to_b)
  );

  assign m_iresp  = sel ? iresp_b  : iresp_a;
  assign m_dresp  = sel ? dresp_b  : dresp_a;
  assign m_rd     = sel ? rd_b     : rd_a;
  assign m_wr     = sel ? wr_b     : wr_a;
  assign m_to     = sel ? to_b     : to_a;
  assign m_irdata = sel ? irdata_b : irdata_a;
  assign m_drdata = sel ? drdata_b : drdata_a;
  assign m_wdata  = sel ? wdata_b  : wdata_a;
  assign m_addr   = sel ? addr_b   : addr_a;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // Called in IDLE; the next edge must grant the expected side, L2 answers in the first SERVE cycle.
  task automatic do_grant(input bit exp_mem, input logic [15:0] exp_addr, input bit exp_wr,
                          input logic [127:0] exp_wd, input logic [127:0] rd, input string tag);
    tick();
    chk({tag, ".addr"},  m_addr, exp_addr);
    chk({tag, ".write"}, m_wr, exp_wr);
    chk({tag, ".read"},  m_rd, !exp_wr);
    chk({tag, ".wdata"}, m_wdata, exp_wd);
    chk({tag, ".early_resp"}, m_iresp | m_dresp, 1'b0);
    l2_resp  = 1'b1;
    l2_rdata = rd;
    #1;
    chk({tag, ".iresp"}, m_iresp, !exp_mem);
    chk({tag, ".dresp"}, m_dresp, exp_mem);
    chk({tag, ".rdata"}, exp_mem ? m_drdata : m_irdata, rd);
    tick();
    l2_resp  = 1'b0;
    l2_rdata = '0;
    #1;
    chk({tag, ".rel_strobe"}, m_rd | m_wr, 1'b0);
    chk({tag, ".rel_resp"}, m_iresp | m_dresp, 1'b0);
    chk({tag, ".rel_hold"}, exp_mem ? m_drdata : m_irdata, rd);
    tick();
    chk({tag, ".idle_strobe"}, m_rd | m_wr, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0;
    reset_n = 1'b0;
    IF_address = 16'h1230; IF_read = 1'b1; IF_write = 1'b0; IF_wdata = WD_IF;
    MEM_address = 16'h0; MEM_read = 1'b0; MEM_write = 1'b0; MEM_wdata = '0;
    l2_resp = 1'b0; l2_rdata = '0;

    // Reset held two cycles with a pending IF read
    repeat (2) @(posedge clk);
    #1;
    chk("rst.read", m_rd, 1'b0);
    chk("rst.write", m_wr, 1'b0);
    chk("rst.addr", m_addr, 16'h0);
    chk("rst.wdata", m_wdata, '0);
    chk("rst.iresp", m_iresp, 1'b0);
    chk("rst.dresp", m_dresp, 1'b0);
    chk("rst.irdata", m_irdata, '0);
    chk("rst.drdata", m_drdata, '0);
    chk("rst.timeout", m_to, 1'b0);
    chk("rst.mp_read", rd_b, 1'b0);
    reset_n = 1'b1;
    #1;
    chk("rst.idle_read", m_rd, 1'b0);

    // Lone IF read, L2 answers in the third SERVE cycle
    tick();
    chk("ifrd.c1_read", m_rd, 1'b1);
    chk("ifrd.c1_addr", m_addr, 16'h1230);
    chk("ifrd.c1_write", m_wr, 1'b0);
    chk("ifrd.c1_resp", m_iresp | m_dresp, 1'b0);
    tick();
    chk("ifrd.c2_read", m_rd, 1'b1);
    tick();
    l2_resp = 1'b1; l2_rdata = RD_A5;
    #1;
    chk("ifrd.iresp", m_iresp, 1'b1);
    chk("ifrd.irdata", m_irdata, RD_A5);
    chk("ifrd.dresp", m_dresp, 1'b0);
    tick();
    l2_resp = 1'b0; l2_rdata = '0; IF_read = 1'b0;
    #1;
    chk("ifrd.rel_read", m_rd, 1'b0);
    chk("ifrd.rel_iresp", m_iresp, 1'b0);
    chk("ifrd.hold_irdata", m_irdata, RD_A5);
    chk("ifrd.rel_dresp", m_dresp, 1'b0);
    tick();
    chk("ifrd.idle_read", m_rd, 1'b0);
    chk("ifrd.timeout", m_to, 1'b0);

    // Round-robin ties: IF read vs MEM write held continuously
    do_reset();
    IF_read = 1'b1; IF_address = 16'h2000;
    MEM_write = 1'b1; MEM_address = 16'h4440; MEM_wdata = WD_M3;
    for (int i = 0; i < 4; i++) begin
      do_grant(i[0], i[0] ? 16'h4440 : 16'h2000, i[0], i[0] ? WD_M3 : WD_IF,
               {8{i[15:0]}}, "tie_rr");
    end
    IF_read = 1'b0; MEM_write = 1'b0;

    // Fixed MEM priority: MEM wins every tie until it drops
    do_reset();
    sel = 1'b1;
    IF_read = 1'b1; IF_address = 16'h3000;
    MEM_read = 1'b1; MEM_address = 16'h5000; MEM_wdata = WD_M4;
    do_grant(1'b1, 16'h5000, 1'b0, WD_M4, {16{8'h71}}, "mp_mem0");
    do_grant(1'b1, 16'h5000, 1'b0, WD_M4, {16{8'h72}}, "mp_mem1");
    MEM_read = 1'b0;
    do_grant(1'b0, 16'h3000, 1'b0, WD_IF, {16{8'h73}}, "mp_if");
    IF_read = 1'b0;
    sel = 1'b0;

    // Timeout after 4 SERVE cycles; read+write together forwards only the write
    do_reset();
    MEM_read = 1'b1; MEM_write = 1'b1; MEM_address = 16'h6000; MEM_wdata = WD_M5;
    tick();
    chk("to.write", m_wr, 1'b1);
    chk("to.read_masked", m_rd, 1'b0);
    chk("to.addr", m_addr, 16'h6000);
    chk("to.start", m_to, 1'b0);
    for (int k = 1; k < 10; k++) begin
      tick();
      chk($sformatf("to.flag%0d", k), m_to, (k >= 4));
      chk($sformatf("to.held%0d", k), m_wr, 1'b1);
    end
    l2_resp = 1'b1; l2_rdata = RD_5;
    #1;
    chk("to.dresp", m_dresp, 1'b1);
    chk("to.drdata", m_drdata, RD_5);
    tick();
    l2_resp = 1'b0; l2_rdata = '0; MEM_read = 1'b0; MEM_write = 1'b0;
    #1;
    chk("to.rel_write", m_wr, 1'b0);
    chk("to.rel_dresp", m_dresp, 1'b0);
    chk("to.sticky_rel", m_to, 1'b1);
    tick();
    chk("to.sticky_idle", m_to, 1'b1);

    // Reset in the middle of a MEM grant, then a stale l2_resp
    MEM_read = 1'b1; MEM_address = 16'h7000;
    tick();
    chk("mrst.read", m_rd, 1'b1);
    chk("mrst.addr", m_addr, 16'h7000);
    tick();
    chk("mrst.read2", m_rd, 1'b1);
    reset_n = 1'b0;
    tick();
    chk("mrst.drop_read", m_rd, 1'b0);
    chk("mrst.timeout_clr", m_to, 1'b0);
    chk("mrst.dresp", m_dresp, 1'b0);
    reset_n = 1'b1; IF_read = 1'b1; IF_address = 16'h7100;
    l2_resp = 1'b1; l2_rdata = RD_6;
    #1;
    chk("mrst.late_dresp", m_dresp, 1'b0);
    chk("mrst.late_iresp", m_iresp, 1'b0);
    chk("mrst.late_drdata", m_drdata, '0);
    chk("mrst.late_read", m_rd, 1'b0);
    #2;
    l2_resp = 1'b0; l2_rdata = '0;
    do_grant(1'b0, 16'h7100, 1'b0, WD_IF, {16{8'h7E}}, "mrst.tie_if");
    IF_read = 1'b0; MEM_read = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
